// File: rtl/eco_patch_pkg.sv
// Shared types and default widths for the ECO patch engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eco_patch_pkg;

  localparam int IN_W    = 10;  // patch-visible inputs, {B[4:0],A[4:0]}
  localparam int OUT_W   = 3;   // width of the netlist output being corrected
  localparam int N_TERMS = 4;   // number of product terms
  localparam int IDX_W   = 2;   // term slot index width

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_DRAIN,
    CFG_SWAP
  } cfg_state_e;

  // One product term: enable, literal selection, literal inversion, target bits.
  typedef struct packed {
    logic             en;
    logic [IN_W-1:0]  care;
    logic [IN_W-1:0]  pol;
    logic [OUT_W-1:0] tgt;
  } term_t;

endpackage

// File: rtl/eco_term_match.sv
// Single product-term hit detector against the netlist primary inputs.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module eco_term_match
  import eco_patch_pkg::*;
(
  input  term_t           term_i,
  input  logic [IN_W-1:0] data_i,
  output logic            hit_o
);

  // A cared literal is true when the input bit differs from its inversion flag;
  // uncared bits are forced true, so an enabled term with care=0 is constant 1.
  assign hit_o = term_i.en & (&(~term_i.care | (data_i ^ term_i.pol)));

endmodule

// File: rtl/eco_patch_engine.sv
// XORs a programmable sum-of-products correction onto a frozen netlist output.
// Latency: 2 cycles from input accept to out_valid when out_ready is held high.
// Backpressure: each stage holds when the next is full and not accepted; inputs are refused while a commit drains.
module eco_patch_engine
  import eco_patch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [OUT_W-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [IN_W-1:0]  cfg_care,
  input  logic [IN_W-1:0]  cfg_pol,
  input  logic [OUT_W-1:0] cfg_tgt,
  input  logic             cfg_en,
  input  logic             cfg_commit,
  output logic             commit_done
);

  cfg_state_e state_q;
  logic       commit_done_q;

  term_t shadow_q [N_TERMS];
  term_t active_q [N_TERMS];

  // Stage 1 keeps the term hits rather than in_data: the hits are all that
  // stage 2 needs, and the active bank cannot change while a beat is in flight.
  logic               s1_v_q;
  logic [OUT_W-1:0]   s1_y_q;
  logic [N_TERMS-1:0] s1_hit_q;
  logic [N_TERMS-1:0] s1_hit_d;

  logic               s2_v_q;
  logic [OUT_W-1:0]   s2_y_q;
  logic [OUT_W-1:0]   s2_y_d;
  logic [OUT_W-1:0]   corr;

  logic idle;
  logic s1_adv;
  logic s2_adv;
  logic in_fire;

  assign idle    = (state_q == CFG_IDLE);
  assign s2_adv  = !s2_v_q || out_ready;
  assign s1_adv  = !s1_v_q || s2_adv;
  assign in_ready  = s1_adv && idle;
  assign in_fire   = in_valid && in_ready;
  assign cfg_ready = idle;

  assign out_valid   = s2_v_q;
  assign out_y       = s2_y_q;
  assign commit_done = commit_done_q;

  genvar g;
  generate
    for (g = 0; g < N_TERMS; g++) begin : g_term
      eco_term_match u_match (
        .term_i (active_q[g]),
        .data_i (in_data),
        .hit_o  (s1_hit_d[g])
      );
    end
  endgenerate

  // OR together the targets of every term that hit for the stage-1 beat.
  always_comb begin
    corr = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (s1_hit_q[t]) corr = corr | active_q[t].tgt;
    end
    s2_y_d = s1_y_q ^ corr;
  end

  // Two-stage valid/ready pipeline; a stage loads only when it can hand off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_y_q   <= '0;
      s1_hit_q <= '0;
      s2_v_q   <= 1'b0;
      s2_y_q   <= '0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= in_fire;
        if (in_fire) begin
          s1_y_q   <= in_y;
          s1_hit_q <= s1_hit_d;
        end
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_y_q <= s2_y_d;
      end
    end
  end

  // Shadow bank takes term writes only while idle; out-of-range slots are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TERMS; t++) shadow_q[t] <= '0;
    end else if (cfg_valid && cfg_ready && (int'(cfg_idx) < N_TERMS)) begin
      shadow_q[cfg_idx] <= '{en: cfg_en, care: cfg_care, pol: cfg_pol, tgt: cfg_tgt};
    end
  end

  // Commit sequencer: drain the pipeline, then copy shadow to active in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CFG_IDLE;
      commit_done_q <= 1'b0;
      for (int t = 0; t < N_TERMS; t++) active_q[t] <= '0;
    end else begin
      commit_done_q <= 1'b0;
      case (state_q)
        CFG_IDLE: begin
          if (cfg_commit) state_q <= CFG_DRAIN;
        end
        CFG_DRAIN: begin
          if (!s1_v_q && !s2_v_q) state_q <= CFG_SWAP;
        end
        CFG_SWAP: begin
          for (int t = 0; t < N_TERMS; t++) active_q[t] <= shadow_q[t];
          commit_done_q <= 1'b1;
          state_q       <= CFG_IDLE;
        end
        default: state_q <= CFG_IDLE;
      endcase
    end
  end

endmodule
